ps2_receiver: RTL
=================

PS2_RECEIVER -- requirements
Module: ps2_receiver

Interface
REQ-001 Parameter DATA_WIDTH, 8, payload bits per PS/2 frame.
REQ-002 Parameter FILTER_LEN, 4, consecutive identical clk samples required to change the filtered ps2_clk level.
REQ-003 Parameter TIMEOUT_CYCLES, 50000, clk cycles without a filtered ps2_clk falling edge before a partial frame is aborted.
REQ-004 clk  input  1  system clock; all state SHALL be clocked on its rising edge.
REQ-005 reset_L  input  1  asynchronous, active-low reset.
REQ-006 ps2_clk  input  1  raw PS/2 clock line; asynchronous to clk.
REQ-007 ps2_data  input  1  raw PS/2 data line; asynchronous to clk.
REQ-008 data_out  output  DATA_WIDTH  last correctly received byte.
REQ-009 valid  output  1  one-cycle pulse: data_out was updated this cycle.
REQ-010 parity_err  output  1  one-cycle pulse: frame dropped on odd-parity failure.
REQ-011 frame_err  output  1  one-cycle pulse: frame dropped on bad start bit, bad stop bit or timeout.

Function
REQ-012 ps2_clk and ps2_data SHALL each pass through a two-flop synchronizer before any other use.
REQ-013 Filtered clock SHALL change level only after FILTER_LEN consecutive identical synchronized samples; it resets to 1.
REQ-014 A falling edge SHALL be flagged in the cycle the filtered clock goes 1->0; ps2_data is sampled from the second synchronizer stage in that same cycle.
REQ-015 FSM states: IDLE, DATA, PARITY, STOP; all transitions occur only on a flagged falling edge, except the timeout.
REQ-016 IDLE: on an edge with sampled bit 0 -> DATA, clear bit counter; with sampled bit 1 -> stay IDLE and pulse frame_err.
REQ-017 DATA: shift the sampled bit in LSB-first; after the DATA_WIDTH-th bit -> PARITY.
REQ-018 PARITY: capture the parity bit -> STOP.
REQ-019 STOP: on an edge go to IDLE; if stop bit is 1 and XOR(payload, parity) is 1, load data_out and pulse valid in the following cycle.
REQ-020 STOP with stop bit 0: pulse frame_err; data_out unchanged; parity not checked.
REQ-021 STOP with stop bit 1 and even total parity: pulse parity_err; data_out unchanged.
REQ-022 At most one of valid, parity_err, frame_err SHALL be asserted in any cycle; each pulse lasts exactly one cycle.
REQ-023 Timeout counter clears on every flagged edge and in IDLE; it increments in DATA/PARITY/STOP and saturates at TIMEOUT_CYCLES-1.
REQ-024 On reaching TIMEOUT_CYCLES-1 outside IDLE: -> IDLE, pulse frame_err, discard the partial shift register.
REQ-025 When an edge and a timeout occur in the same cycle, the edge SHALL take priority and the timeout SHALL be ignored.
REQ-026 data_out SHALL hold its value between valid pulses; it SHALL never expose partial shift-register contents.
REQ-027 Latency: valid SHALL rise 1 clk cycle after the cycle in which the stop-bit edge is flagged.
REQ-028 Block SHALL never drive ps2_clk or ps2_data; receive-only.

Reset
REQ-029 While reset_L=0: FSM=IDLE, synchronizers and filter=1, bit and timeout counters=0, data_out=0, valid=parity_err=frame_err=0.
REQ-030 Reset SHALL take effect asynchronously and abort any frame in progress with no error pulse.
REQ-031 The first frame after reset_L deasserts SHALL be received normally, starting from its start bit.

Verification
REQ-032 Frame 0x1C, parity 0, stop 1, at 12.5 kHz PS/2 clock -> single valid pulse, data_out=0x1C, no error pulses.
REQ-033 Frame 0xF0 with parity forced to 0 -> parity_err pulse only; data_out keeps its previous value (0x1C).
REQ-034 Frame 0x75 with stop bit 0 -> frame_err pulse only; the next good frame 0x6B -> valid pulse, data_out=0x6B.
REQ-035 5 data bits sent, then ps2_clk held high for TIMEOUT_CYCLES cycles -> frame_err pulse, FSM=IDLE; the following frame 0x24 -> valid pulse, data_out=0x24.
REQ-036 A low glitch of FILTER_LEN-1 cycles on ps2_clk inside frame 0x1D -> no extra bit shifted; valid pulse, data_out=0x1D.
REQ-037 reset_L pulsed low after the 4th data bit -> all outputs 0 immediately, no error pulse; the next frame 0x23 -> valid pulse, data_out=0x23.

Source files
------------

// File: rtl/ps2_receiver.sv
// PS/2 device-to-host receiver: synchronizes and deglitches ps2_clk, then deframes start/8 data/odd parity/stop.
// Latency: valid/parity_err/frame_err rise one core cycle after the filtered stop-bit falling edge.
// Backpressure: none; receive-only, results are single-cycle pulses that must be consumed when seen.
`timescale 1ns/1ps
module ps2_receiver #(
  parameter int DATA_WIDTH     = 8,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic                  ps2_clk,
  input  logic                  ps2_data,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid,
  output logic                  parity_err,
  output logic                  frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  // Two-stage synchronizers; idle level of both lines is high.
  logic clk_s1_q, clk_s2_q;
  logic dat_s1_q, dat_s2_q;

  // Deglitch filter state.
  logic          filt_q, filt_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          fall_w;

  // Deframer state.
  state_t                 state_q;
  logic [BW-1:0]          bit_q;
  logic [DATA_WIDTH-1:0]  shift_q;
  logic                   par_q;
  logic [TW-1:0]          to_q;

  // Bring both raw PS/2 lines into the clk domain.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
    end else begin
      clk_s1_q <= ps2_clk;
      clk_s2_q <= clk_s1_q;
      dat_s1_q <= ps2_data;
      dat_s2_q <= dat_s1_q;
    end
  end

  // Count consecutive samples that disagree with the filtered level; flip once FILTER_LEN agree.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (clk_s2_q != filt_q) begin
      if (fcnt_q == FILT_LAST) begin
        filt_d = clk_s2_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
  end

  // The falling edge is flagged in the same cycle the filtered level is about to drop.
  assign fall_w = filt_q & ~filt_d;

  // Register the filtered clock level and its agreement counter.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      filt_q <= 1'b1;
      fcnt_q <= '0;
    end else begin
      filt_q <= filt_d;
      fcnt_q <= fcnt_d;
    end
  end

  // Frame FSM with registered result pulses; an edge always wins over a same-cycle timeout.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q    <= IDLE;
      bit_q      <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      to_q       <= '0;
      data_out   <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      if (fall_w) begin
        to_q <= '0;
        case (state_q)
          IDLE: begin
            if (!dat_s2_q) begin
              state_q <= DATA;
              bit_q   <= '0;
            end else begin
              frame_err <= 1'b1;
            end
          end
          DATA: begin
            shift_q <= {dat_s2_q, shift_q[DATA_WIDTH-1:1]};
            bit_q   <= bit_q + 1'b1;
            if (bit_q == BIT_LAST) begin
              state_q <= PARITY;
            end
          end
          PARITY: begin
            par_q   <= dat_s2_q;
            state_q <= STOP;
          end
          STOP: begin
            state_q <= IDLE;
            if (!dat_s2_q) begin
              frame_err <= 1'b1;
            end else if (^{shift_q, par_q}) begin
              data_out <= shift_q;
              valid    <= 1'b1;
            end else begin
              parity_err <= 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end else if (state_q != IDLE) begin
        if (to_q == TO_LAST) begin
          // Line went quiet mid-frame: drop the partial byte and report it.
          state_q   <= IDLE;
          shift_q   <= '0;
          to_q      <= '0;
          frame_err <= 1'b1;
        end else begin
          to_q <= to_q + 1'b1;
        end
      end else begin
        to_q <= '0;
      end
    end
  end

endmodule
